// File: rtl/scope_pkg.sv
// Shared encodings and constants for the scope trigger/acquisition controller.
// Latency: n/a (types and constants only).
// Backpressure: none; the sample stream is strobe-based and cannot be stalled.
package scope_pkg;

  localparam int         SAMPLE_W     = 16;
  localparam logic [2:0] YSCALE_RESET = 3'd2;
  localparam logic [2:0] YSCALE_MAX   = 3'd7;

  typedef enum logic [2:0] {
    ST_STOP   = 3'd0,
    ST_ARM    = 3'd1,
    ST_WINDOW = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_AUTO   = 2'd0,
    MODE_NORMAL = 2'd1,
    MODE_SINGLE = 2'd2
  } mode_t;

  // AUTO -> NORMAL -> SINGLE -> AUTO
  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_AUTO:   return MODE_NORMAL;
      MODE_NORMAL: return MODE_SINGLE;
      default:     return MODE_AUTO;
    endcase
  endfunction

endpackage

// File: rtl/scope_trig_detect.sv
// Rising-edge threshold detector: remembers the previous strobed sample.
// Latency: trig is combinational on the current strobe; prev updates at the edge.
// Backpressure: none; every strobe updates prev regardless of controller state.
module scope_trig_detect
  import scope_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trig_level,
  output logic                trig
);

  logic [SAMPLE_W-1:0] prev;

  // prev starts at the most negative value so the first strobe can cross upward
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           prev <= {1'b1, {(SAMPLE_W-1){1'b0}}};
    else if (new_sample) prev <= sample;
  end

  // signed upward crossing of the threshold on this strobe
  always_comb begin
    trig = new_sample
        && ($signed(prev) < $signed(trig_level))
        && ($signed(sample) >= $signed(trig_level));
  end

endmodule

// File: rtl/scope_trigger_ctrl.sv
// Trigger/acquisition controller gating sample strobes into the capture path; owns yscale.
// Latency: forwarded strobe/sample 1 cycle after new_sample; buttons visible next cycle.
// Backpressure: none; optional holdoff state compiled in with SCOPE_HOLDOFF_EN.
module scope_trigger_ctrl
  import scope_pkg::*;
#(
  parameter int WINDOW_LEN   = 512,
  parameter int AUTO_TIMEOUT = 4096
`ifdef SCOPE_HOLDOFF_EN
  , parameter int HOLDOFF_LEN = 256
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_sample,
  input  logic [15:0] sample,
  input  logic        vsync,
  input  logic [15:0] trig_level,
  input  logic        btn_run,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic        new_sample_out,
  output logic [15:0] sample_out,
  output logic [2:0]  yscale,
  output logic [1:0]  mode,
  output logic        running,
  output logic        triggered
);

  localparam logic [15:0] WIN_END  = 16'(WINDOW_LEN);
  localparam logic [15:0] AUTO_END = 16'(AUTO_TIMEOUT);
`ifdef SCOPE_HOLDOFF_EN
  localparam logic [15:0] HOLD_END = 16'(HOLDOFF_LEN);
  logic [15:0] hold_cnt, hold_cnt_n, hold_b;
`endif

  state_t      state, state_n, st_b, end_st;
  mode_t       mode_q, mode_n;
  logic [15:0] arm_cnt, arm_cnt_n, arm_b;
  logic [15:0] win_cnt, win_cnt_n, win_b;
  logic [2:0]  pend_scale, pend_scale_n;
  logic        clr, fwd, trig, running_n, triggered_n;

  scope_trig_detect u_detect (
    .clk        (clk),
    .reset      (reset),
    .new_sample (new_sample),
    .sample     (sample),
    .trig_level (trig_level),
    .trig       (trig)
  );

  // state, mode and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_ARM;
      mode_q  <= MODE_AUTO;
      arm_cnt <= '0;
      win_cnt <= '0;
`ifdef SCOPE_HOLDOFF_EN
      hold_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      mode_q  <= mode_n;
      arm_cnt <= arm_cnt_n;
      win_cnt <= win_cnt_n;
`ifdef SCOPE_HOLDOFF_EN
      hold_cnt <= hold_cnt_n;
`endif
    end
  end

  // next state: buttons act first, then the strobe is judged against the post-button state
  always_comb begin
    mode_n = btn_mode ? next_mode(mode_q) : mode_q;
    st_b   = state;
    clr    = 1'b0;
    if (btn_run) begin
      st_b = (state == ST_STOP || state == ST_DONE) ? ST_ARM : ST_STOP;
      clr  = 1'b1;
    end else if (btn_mode && state != ST_STOP) begin
      st_b = ST_ARM;
      clr  = 1'b1;
    end
    arm_b = clr ? 16'd0 : arm_cnt;
    win_b = clr ? 16'd0 : win_cnt;
`ifdef SCOPE_HOLDOFF_EN
    hold_b     = clr ? 16'd0 : hold_cnt;
    hold_cnt_n = hold_b;
    end_st     = (mode_n == MODE_SINGLE) ? ST_DONE : ST_HOLD;
`else
    end_st     = (mode_n == MODE_SINGLE) ? ST_DONE : ST_ARM;
`endif
    state_n   = st_b;
    arm_cnt_n = arm_b;
    win_cnt_n = win_b;
    fwd       = 1'b0;
    case (st_b)
      ST_ARM: begin
        if (new_sample) begin
          if (trig || (mode_n == MODE_AUTO && (arm_b + 16'd1) == AUTO_END)) begin
            // the opening sample is window sample 1
            fwd       = 1'b1;
            arm_cnt_n = '0;
            if (WIN_END == 16'd1) begin
              state_n   = end_st;
              win_cnt_n = '0;
            end else begin
              state_n   = ST_WINDOW;
              win_cnt_n = 16'd1;
            end
          end else if (mode_n == MODE_AUTO) begin
            arm_cnt_n = arm_b + 16'd1;
          end
        end
      end
      ST_WINDOW: begin
        if (new_sample) begin
          fwd = 1'b1;
          if ((win_b + 16'd1) == WIN_END) begin
            state_n   = end_st;
            win_cnt_n = '0;
          end else begin
            win_cnt_n = win_b + 16'd1;
          end
        end
      end
`ifdef SCOPE_HOLDOFF_EN
      ST_HOLD: begin
        if (new_sample) begin
          if ((hold_b + 16'd1) == HOLD_END) begin
            state_n    = ST_ARM;
            hold_cnt_n = '0;
          end else begin
            hold_cnt_n = hold_b + 16'd1;
          end
        end
      end
`endif
      default: ;
    endcase
  end

  // status flags decoded from the state being entered
  always_comb begin
    running_n   = !(state_n == ST_STOP || state_n == ST_DONE);
    triggered_n = (state_n == ST_WINDOW);
  end

  // registered outputs; sample_out holds its last forwarded value
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      new_sample_out <= 1'b0;
      sample_out     <= '0;
      running        <= 1'b1;
      triggered      <= 1'b0;
    end else begin
      new_sample_out <= fwd;
      if (fwd) sample_out <= sample;
      running        <= running_n;
      triggered      <= triggered_n;
    end
  end

  assign mode = mode_q;

  // pending scale: saturating up/down, simultaneous presses cancel
  always_comb begin
    pend_scale_n = pend_scale;
    if (btn_up && !btn_down && pend_scale != YSCALE_MAX)
      pend_scale_n = pend_scale + 3'd1;
    else if (btn_down && !btn_up && pend_scale != 3'd0)
      pend_scale_n = pend_scale - 3'd1;
  end

  // scale changes reach the display only while it is idle (vsync low)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_scale <= YSCALE_RESET;
      yscale     <= YSCALE_RESET;
    end else begin
      pend_scale <= pend_scale_n;
      if (!vsync) yscale <= pend_scale;
    end
  end

endmodule
